dmem_responder: RTL

Data-memory responder for the single-cycle CPU's DM bus (DM_CS/DM_R/DM_W, DM_addr, DM_wdata, rdata). It serves a word-addressed data RAM plus a small MMIO page with a free-running cycle counter, a RAM-store counter and a 4-entry byte output FIFO drained by an external valid/ready consumer. Reads are combinational so the CPU completes loads in one cycle. Writes commit on the clock edge.

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/out_fifo.sv | 52 +++++
 rtl/dmem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, MMIO register map and decode/status helpers for the
// data-memory responder.
package dmem_pkg;

  localparam logic [31:0] RAM_BASE_DEF  = 32'h1001_0000;
  localparam int unsigned RAM_WORDS_DEF = 1024;
  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PW    = 2;
  localparam int unsigned FIFO_CW    = 3;

  // STATUS register bit positions
  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_COUNT_LSB = 2;
  localparam int unsigned ST_OVF       = 5;

  // MMIO word select, taken from DM_addr[3:2]
  typedef enum logic [1:0] {
    MMIO_CYCLE  = 2'd0,
    MMIO_STORES = 2'd1,
    MMIO_OUT    = 2'd2,
    MMIO_STATUS = 2'd3
  } mmio_reg_e;

  typedef struct packed {
    logic      access;
    logic      ram_hit;
    logic      mmio_hit;
    logic      aligned;
    logic      ok;
    logic      bad;
    mmio_reg_e sel;
  } dm_dec_t;

  function automatic logic [31:0] pack_status(input logic               full,
                                              input logic               empty,
                                              input logic [FIFO_CW-1:0] count,
                                              input logic               ovf);
    logic [31:0] s;
    s                          = '0;
    s[ST_FULL]                 = full;
    s[ST_EMPTY]                = empty;
    s[ST_COUNT_LSB +: FIFO_CW] = count;
    s[ST_OVF]                  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/out_fifo.sv
// 4-entry byte FIFO, first-word-fall-through; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module out_fifo
  import dmem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [7:0]         data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_CW-1:0] count_o,
  output logic [7:0]         data_o
);

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wptr_q, wptr_d;
  logic [FIFO_PW-1:0] rptr_q, rptr_d;
  logic [FIFO_CW-1:0] count_q, count_d;
  logic               push_en, pop_en;

  always_comb begin
    full_o  = (count_q == FIFO_CW'(FIFO_DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
    data_o  = empty_o ? 8'h00 : mem_q[rptr_q];
    pop_en  = pop_i & ~empty_o;
    push_en = push_i & (~full_o | pop_en);
    wptr_d  = wptr_q + FIFO_PW'(push_en);
    rptr_d  = rptr_q + FIFO_PW'(pop_en);
    count_d = count_q + FIFO_CW'(push_en) - FIFO_CW'(pop_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_responder.sv
// DM bus responder: word RAM with combinational reads plus an MMIO page
// holding a cycle counter, a store counter and a byte output FIFO.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter int unsigned RAM_WORDS = RAM_WORDS_DEF,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] rdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        err
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]        ram_q [RAM_WORDS];
  dm_dec_t            dec;
  logic [31:0]        ram_off;
  logic [RAM_AW-1:0]  ram_idx;
  logic [31:0]        cycle_q, cycle_d;
  logic [31:0]        stores_q, stores_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               ram_we, out_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic [7:0]         fifo_data;

  // Address decode; the unsigned offset compare also rejects addresses below the base
  always_comb begin
    ram_off      = DM_addr - RAM_BASE;
    ram_idx      = ram_off[RAM_AW+1:2];
    dec          = '0;
    dec.access   = DM_CS & (DM_R | DM_W);
    dec.ram_hit  = (ram_off < RAM_BYTES);
    dec.mmio_hit = (DM_addr[31:4] == MMIO_BASE[31:4]);
    dec.aligned  = (DM_addr[1:0] == 2'b00);
    dec.ok       = dec.access & dec.aligned & (dec.ram_hit | dec.mmio_hit);
    dec.bad      = dec.access & ~dec.ok;
    dec.sel      = mmio_reg_e'(DM_addr[3:2]);
  end

  always_comb begin
    ram_we   = dec.ok & DM_W & dec.ram_hit;
    out_push = dec.ok & DM_W & ~dec.ram_hit & dec.mmio_hit & (dec.sel == MMIO_OUT);
    fifo_pop = out_ready & ~fifo_empty;
    cycle_d  = cycle_q + 32'd1;
    stores_d = stores_q + 32'(ram_we);
    ovf_d    = ovf_q | (out_push & fifo_full & ~fifo_pop);
    err_d    = err_q | dec.bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q  <= '0;
      stores_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // RAM is not reset, but a store coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) ram_q[ram_idx] <= DM_wdata;
  end

  out_fifo u_out_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (out_push),
    .data_i  (DM_wdata[7:0]),
    .pop_i   (out_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .data_o  (fifo_data)
  );

  // Combinational load path; a simultaneous store still returns the old word
  always_comb begin
    rdata = '0;
    if (dec.ok && DM_R) begin
      if (dec.ram_hit) begin
        rdata = ram_q[ram_idx];
      end else begin
        case (dec.sel)
          MMIO_CYCLE:  rdata = cycle_q;
          MMIO_STORES: rdata = stores_q;
          MMIO_STATUS: rdata = pack_status(fifo_full, fifo_empty, fifo_count, ovf_q);
          default:     rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    out_valid = ~fifo_empty;
    out_data  = fifo_data;
    err       = err_q;
  end

endmodule
